// File: rtl/idct_transpose_4x4.sv
// -----------------------------------------------------------------------------
// idct_transpose_4x4
//
// Ping-pong transpose buffer between the row pass and the column pass of a
// 4x4 IDCT. Samples arrive row-major, 16 per block, and are stored in one of
// two 16-entry banks. Once a bank holds a complete block it is read out in
// column-major order (entries 0,4,8,12,1,5,...,15) while the other bank
// fills. Sustained rate is one sample per cycle in and one per cycle out.
//
// Optional feature macro: TRANSPOSE_CLIP16_EN
//   When defined, every accepted sample is saturated to [-32768, 32767]
//   before it is stored (result sign-extended to DW bits). When undefined,
//   samples are stored at full DW width unchanged.
//
// Ports
//   clk       : clock, all state changes on the rising edge
//   reset     : asynchronous, active-high reset
//   in_valid  : in_data carries a row-pass sample
//   in_data   : signed DW-bit sample, row-major within the block
//   in_ready  : the buffer accepts in_data this cycle
//   out_valid : out_data carries a transposed sample
//   out_data  : signed DW-bit sample, column-major; 0 while out_valid=0
//   out_ready : the column-pass stage consumes out_data this cycle
//   out_last  : marks the 16th sample of each output block
// -----------------------------------------------------------------------------
module idct_transpose_4x4 #(
  parameter int DW = 25
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic signed [DW-1:0] in_data,
  output logic                 in_ready,
  output logic                 out_valid,
  output logic signed [DW-1:0] out_data,
  input  logic                 out_ready,
  output logic                 out_last
);

  typedef enum logic [1:0] {
    BANK_EMPTY   = 2'd0,
    BANK_FILLING = 2'd1,
    BANK_FULL    = 2'd2
  } bank_state_t;

  bank_state_t bank_state_reg [2];

  logic       wr_ptr_reg;
  logic       rd_ptr_reg;
  logic [3:0] wr_idx_reg;
  logic [3:0] rd_idx_reg;

  logic       wr_ptr_next;
  logic       rd_ptr_next;
  logic [3:0] wr_idx_next;
  logic [3:0] rd_idx_next;

  logic in_fire;
  logic out_fire;

  // Bank 0 occupies addresses 0..15, bank 1 addresses 16..31.
  logic signed [DW-1:0] mem [0:31];
  logic signed [DW-1:0] rd_data_reg;
  logic signed [DW-1:0] wr_data;
  logic [4:0]           wr_addr;
  logic [4:0]           rd_addr_next;

  // ---------------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------------
  // The write pointer only lands on a FULL bank when both banks are full,
  // and the read pointer only sees FULL on a bank that is done filling, so an
  // input and an output transfer in the same cycle always touch different
  // banks.
  assign in_ready  = (bank_state_reg[wr_ptr_reg] != BANK_FULL);
  assign out_valid = (bank_state_reg[rd_ptr_reg] == BANK_FULL);
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;
  assign out_last  = out_valid && (rd_idx_reg == 4'd15);

  // ---------------------------------------------------------------------------
  // Index / pointer next-state
  // ---------------------------------------------------------------------------
  always_comb begin
    wr_idx_next = wr_idx_reg;
    wr_ptr_next = wr_ptr_reg;
    rd_idx_next = rd_idx_reg;
    rd_ptr_next = rd_ptr_reg;
    if (in_fire) begin
      wr_idx_next = wr_idx_reg + 4'd1;
      if (wr_idx_reg == 4'd15) begin
        wr_ptr_next = ~wr_ptr_reg;
      end
    end
    if (out_fire) begin
      rd_idx_next = rd_idx_reg + 4'd1;
      if (rd_idx_reg == 4'd15) begin
        rd_ptr_next = ~rd_ptr_reg;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_idx_reg <= 4'd0;
      wr_ptr_reg <= 1'b0;
      rd_idx_reg <= 4'd0;
      rd_ptr_reg <= 1'b0;
    end else begin
      wr_idx_reg <= wr_idx_next;
      wr_ptr_reg <= wr_ptr_next;
      rd_idx_reg <= rd_idx_next;
      rd_ptr_reg <= rd_ptr_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Per-bank state. A bank moves to FULL on its 16th write and back to EMPTY
  // on its 16th read, in the same edge as the pointer toggle, so there is no
  // idle cycle between consecutive blocks.
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < 2; gi++) begin : g_bank
    logic wr_sel;
    logic rd_sel;
    assign wr_sel = (wr_ptr_reg == 1'(gi));
    assign rd_sel = (rd_ptr_reg == 1'(gi));

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        bank_state_reg[gi] <= BANK_EMPTY;
      end else if (in_fire && wr_sel) begin
        bank_state_reg[gi] <= (wr_idx_reg == 4'd15) ? BANK_FULL : BANK_FILLING;
      end else if (out_fire && rd_sel && (rd_idx_reg == 4'd15)) begin
        bank_state_reg[gi] <= BANK_EMPTY;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Write data path
  // ---------------------------------------------------------------------------
`ifdef TRANSPOSE_CLIP16_EN
  localparam logic signed [DW-1:0] SAT_MAX = DW'(32767);
  localparam logic signed [DW-1:0] SAT_MIN = DW'(-32768);

  always_comb begin
    if (in_data > SAT_MAX) begin
      wr_data = SAT_MAX;
    end else if (in_data < SAT_MIN) begin
      wr_data = SAT_MIN;
    end else begin
      wr_data = in_data;
    end
  end
`else
  assign wr_data = in_data;
`endif

  assign wr_addr = {wr_ptr_reg, wr_idx_reg};

  // Output step j reads entry (j mod 4)*4 + (j div 4): the two halves of the
  // step index swap places. The address is formed from the *next* read state
  // so the registered read already holds the right entry when the step is
  // presented. The entry fetched is never the one written on the same edge:
  // a bank being read is FULL and not written, and a bank turning FULL takes
  // its last write at entry 15 while the first read targets entry 0.
  assign rd_addr_next = {rd_ptr_next, rd_idx_next[1:0], rd_idx_next[3:2]};

  always_ff @(posedge clk) begin
    if (in_fire) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data_reg <= mem[rd_addr_next];
  end

  assign out_data = out_valid ? rd_data_reg : '0;

endmodule

// File: tb/tb_idct_transpose_4x4.sv
// -----------------------------------------------------------------------------
// tb_idct_transpose_4x4
//
// Self-checking bench for idct_transpose_4x4. The reference model is a queue
// of expected output samples: each completed input block is appended in
// transposed order. Handshake expectations follow from the queue occupancy
// (complete blocks still waiting to be read).
// -----------------------------------------------------------------------------
module tb_idct_transpose_4x4;

  localparam int DW = 25;

  logic                 clk;
  logic                 reset;
  logic                 in_valid;
  logic signed [DW-1:0] in_data;
  logic                 in_ready;
  logic                 out_valid;
  logic signed [DW-1:0] out_data;
  logic                 out_ready;
  logic                 out_last;

  idct_transpose_4x4 #(.DW(DW)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .out_last  (out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  int acc_cnt = 0;
  logic last_acc;

  logic signed [DW-1:0] exp_q [$];   // transposed samples awaiting output
  logic signed [DW-1:0] part  [$];   // samples of the block being received

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      $error("FAIL %s: observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  function automatic logic signed [DW-1:0] stored_value(input logic signed [DW-1:0] v);
`ifdef TRANSPOSE_CLIP16_EN
    if (v > 32767) return DW'(32767);
    if (v < -32768) return DW'(-32768);
`endif
    return v;
  endfunction

  // One clock cycle: check outputs at the falling edge, advance the model by
  // whatever transfers happen at the next rising edge.
  task automatic cycle();
    int  blocks;
    logic exp_rdy, exp_vld, exp_lst;
    logic signed [DW-1:0] exp_dat;
    @(negedge clk);
    blocks  = (exp_q.size() + 15) / 16;
    exp_rdy = (blocks < 2);
    exp_vld = (exp_q.size() > 0);
    exp_dat = exp_vld ? exp_q[0] : '0;
    exp_lst = exp_vld && ((exp_q.size() % 16) == 1);
    check("in_ready",  DW'(in_ready),  DW'(exp_rdy));
    check("out_valid", DW'(out_valid), DW'(exp_vld));
    check("out_data",  out_data,       exp_dat);
    check("out_last",  DW'(out_last),  DW'(exp_lst));
    last_acc = in_valid && exp_rdy;
    if (last_acc) begin
      acc_cnt++;
      part.push_back(stored_value(in_data));
      if (part.size() == 16) begin
        for (int j = 0; j < 16; j++) exp_q.push_back(part[(j % 4) * 4 + j / 4]);
        part.delete();
      end
    end
    if (exp_vld && out_ready) begin
      $display("out data=%0d last=%0b", out_data, out_last);
      void'(exp_q.pop_front());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    check("rst_in_ready",  DW'(in_ready),  DW'(1'b1));
    check("rst_out_valid", DW'(out_valid), DW'(1'b0));
    check("rst_out_data",  out_data,       '0);
    check("rst_out_last",  DW'(out_last),  DW'(1'b0));
    exp_q.delete();
    part.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Offer one sample until accepted (bounded).
  task automatic send(input logic signed [DW-1:0] v);
    int guard = 0;
    in_valid = 1'b1;
    in_data  = v;
    do begin
      cycle();
      guard++;
    end while (!last_acc && guard < 200);
    if (!last_acc) check("send_timeout", DW'(1'b0), DW'(1'b1));
    in_valid = 1'b0;
  endtask

  task automatic send_block(input int base);
    for (int k = 0; k < 16; k++) send(DW'(base + k));
  endtask

  task automatic drain();
    int guard = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while (exp_q.size() > 0 && guard < 80) begin
      cycle();
      guard++;
    end
    check("drain_empty", DW'(exp_q.size()), '0);
    cycle();
  endtask

  task automatic rand_data();
    logic [31:0] tmp;
    tmp     = $urandom;
    in_data = tmp[DW-1:0];
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    last_acc  = 1'b0;

    // Reset state and single block back-to-back.
    do_reset();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int k = 0; k < 16; k++) begin
      in_data = DW'(k);
      cycle();
    end
    in_valid = 1'b0;
    drain();

    // Two blocks continuous, full throughput.
    in_valid = 1'b1;
    for (int k = 0; k < 32; k++) begin
      in_data = (k < 16) ? DW'(k) : DW'(100 + k - 16);
      cycle();
    end
    in_valid = 1'b0;
    drain();

    // Output stalled: both banks fill, then input is back-pressured.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    acc_cnt   = 0;
    for (int c = 0; c < 40; c++) begin
      rand_data();
      cycle();
    end
    check("accepts_when_stalled", DW'(acc_cnt), DW'(32));
    in_valid = 1'b0;
    drain();

    // out_ready toggling with random input traffic.
    for (int c = 0; c < 200; c++) begin
      out_ready = c[0];
      in_valid  = 1'(($urandom % 4) != 0);
      rand_data();
      cycle();
    end
    in_valid = 1'b0;
    drain();

    // Boundary values around the 16-bit range.
    send(DW'(40000));
    send(DW'(-40000));
    send(DW'(32767));
    send(DW'(-32768));
    for (int k = 0; k < 12; k++) send(DW'(k - 6));
    drain();

    // Reset after a partial block; only the following block may come out.
    send_block(500);
    do_reset();
    do_reset();
    for (int k = 0; k < 7; k++) send(DW'(900 + k));
    do_reset();
    send_block(0);
    drain();

    // Fully random handshake on both sides.
    for (int c = 0; c < 600; c++) begin
      out_ready = 1'(($urandom % 3) != 0);
      in_valid  = 1'(($urandom % 3) != 0);
      rand_data();
      cycle();
    end
    in_valid = 1'b0;
    drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/idct_transpose_4x4.md
IDCT_TRANSPOSE_4X4 -- requirements
Module: idct_transpose_4x4

Interface
REQ-001 The block SHALL have parameter DW, default 25, giving the sample width in bits (signed two's complement).
REQ-002 The block SHALL have input clk, 1 bit, the clock; all state SHALL change on the rising edge.
REQ-003 The block SHALL have input reset, 1 bit, asynchronous, active-high.
REQ-004 The block SHALL have input in_valid, 1 bit, meaning in_data carries a first-pass IDCT output sample.
REQ-005 The block SHALL have input in_data, DW bits signed, the sample, delivered row-major within a 4x4 block.
REQ-006 The block SHALL have output in_ready, 1 bit, meaning the block accepts in_data this cycle.
REQ-007 The block SHALL have output out_valid, 1 bit, meaning out_data holds a valid transposed sample.
REQ-008 The block SHALL have output out_data, DW bits signed, the sample, emitted column-major.
REQ-009 The block SHALL have input out_ready, 1 bit, meaning the second-pass stage consumes out_data this cycle.
REQ-010 The block SHALL have output out_last, 1 bit, asserted with the 16th sample of each output block.

Function
REQ-011 Storage SHALL be two banks (ping-pong) of 16 x DW; each bank is EMPTY, FILLING or FULL.
REQ-012 Transfers: input on in_valid && in_ready; output on out_valid && out_ready.
REQ-013 Input sample k (0..15) of a block SHALL be written to entry k of the write bank; wr_idx increments per input transfer.
REQ-014 On the 16th input transfer the write bank SHALL become FULL, wr_idx wraps to 0 and the write pointer toggles.
REQ-015 in_ready SHALL be 1 exactly when the write bank is not FULL.
REQ-016 out_valid SHALL be 1 exactly when the read bank is FULL; first out_valid SHALL occur the cycle after the 16th input transfer.
REQ-017 Output step j (0..15) SHALL present entry (j mod 4)*4 + (j div 4), i.e. transpose order 0,4,8,12,1,5,...,15.
REQ-018 On the 16th output transfer the read bank SHALL become EMPTY, rd_idx wraps to 0 and the read pointer toggles; out_last SHALL be 1 only when rd_idx=15 and out_valid=1.
REQ-019 out_data and out_last SHALL hold stable while out_valid=1 and out_ready=0; out_data SHALL be 0 when out_valid=0.
REQ-020 Simultaneous input and output transfers on different banks SHALL both complete in one cycle; sustained throughput SHALL be one sample per cycle in and out.
REQ-021 With both banks FULL, in_ready SHALL be 0 until the read bank drains; no accepted sample SHALL be lost or overwritten.
REQ-022 A bank SHALL become FILLING/FULL and EMPTY in the same cycle it is released, with no idle cycle between blocks.

Reset
REQ-023 On reset: both banks EMPTY, wr_idx=rd_idx=0, both pointers at bank 0, in_ready=1, out_valid=0, out_data=0, out_last=0.
REQ-024 Reset mid-block SHALL discard all partial and full blocks; storage contents need not be cleared.
REQ-025 After reset deasserts, the first accepted sample SHALL be treated as entry 0 of a new block.

Configuration
REQ-026 Macro TRANSPOSE_CLIP16_EN: when defined, each sample SHALL be saturated to [-32768, 32767] on write, sign-extended to DW.
REQ-027 When TRANSPOSE_CLIP16_EN is undefined, samples SHALL pass unmodified at full DW width.

Verification
REQ-028 Reset, send 0..15 back-to-back, out_ready=1 -> out_valid first high one cycle after 16th accept; output 0,4,8,12,1,5,9,13,2,6,10,14,3,7,11,15; out_last on 15.
REQ-029 Two blocks (0..15, 100..115) continuous, out_ready=1 -> in_ready stays 1; outputs contiguous, second block starts 100,104,108,112.
REQ-030 out_ready=0, in_valid=1 continuously -> exactly 32 accepts then in_ready=0; release out_ready -> in_ready returns 1 the cycle after 16th output.
REQ-031 out_ready toggling 1/0 -> out_data unchanged across stall cycles; no sample duplicated or dropped.
REQ-032 Inputs 40000 and -40000 -> with TRANSPOSE_CLIP16_EN, 32767 and -32768; without, 40000 and -40000.
REQ-033 Reset after 7 inputs, then send 0..15 -> output exactly one block in transpose order; earlier 7 samples never appear.
